// File: rtl/lsu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_pkg
// Shared definitions for the MEM-stage load/store unit: data-memory geometry,
// request size codes (also used on the memory chip-select lines), memory
// enable encodings and the controller FSM state encoding.
// -----------------------------------------------------------------------------
package lsu_ctrl_pkg;

  // Byte address of data-memory word 0 and memory depth in 32-bit words.
  localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
  localparam int unsigned DMEM_WORDS = 32'd1024;

  // Access size codes; 2'b00 is illegal on requests and means "idle" on mem_*_cs.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  // Memory port enable encodings.
  localparam logic ENABLED        = 1'b1;
  localparam logic DISABLED       = 1'b0;
  localparam logic WRITE_ENABLED  = 1'b1;
  localparam logic WRITE_DISABLED = 1'b0;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational helper for lsu_ctrl.
//   chk_size_i/chk_addr_i -> chk_err_o : illegal size, misalignment or
//                                        out-of-range request
//   ext_rdata_i/ext_size_i/ext_unsigned_i -> ext_data_o : load data extended
//                                        to 32 bits (memory already returns
//                                        sub-word data right-aligned)
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int unsigned NUM_WORDS = DMEM_WORDS
) (
  input  logic [1:0]  chk_size_i,
  input  logic [31:0] chk_addr_i,
  output logic        chk_err_o,
  input  logic [31:0] ext_rdata_i,
  input  logic [1:0]  ext_size_i,
  input  logic        ext_unsigned_i,
  output logic [31:0] ext_data_o
);

  // 33-bit window bounds so BASE + size can never wrap past 2^32.
  localparam logic [32:0] LO_X = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_X = LO_X + (33'(NUM_WORDS) * 33'd4);

  function automatic logic calc_err(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] addr_x;
    logic        misaligned;
    logic        out_of_range;
    addr_x = {1'b0, addr};
    case (size)
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      SZ_HALF: misaligned = addr[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;   // size 00 is illegal
    endcase
    out_of_range = (addr_x < LO_X) || (addr_x >= HI_X);
    return misaligned | out_of_range;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {{24{~is_unsigned & rdata[7]}}, rdata[7:0]};
      SZ_HALF: res = {{16{~is_unsigned & rdata[15]}}, rdata[15:0]};
      SZ_WORD: res = rdata;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign chk_err_o  = calc_err(chk_size_i, chk_addr_i);
  assign ext_data_o = extend_load(ext_rdata_i, ext_size_i, ext_unsigned_i);

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// MEM-stage load/store controller. Accepts one request at a time
// (req_valid_i/req_ready_o), checks it, runs a single-cycle data-memory access
// and returns a registered response (resp_valid_o/resp_ready_i).
//   req_*   : request in (store flag, size, unsigned, address, store data, tag)
//   resp_*  : response out (extended load data, tag, error flag)
//   mem_*   : data-memory initiator port (enable, write enable, size codes,
//             registered address/data, combinational read data in)
// Bad requests skip the memory cycle and respond one cycle after acceptance;
// good ones respond two cycles after acceptance.
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int unsigned NUM_WORDS = DMEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o,
  output logic        mem_ena_o,
  output logic        mem_wena_o,
  output logic [1:0]  mem_w_cs_o,
  output logic [1:0]  mem_r_cs_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic        req_ready_q;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q;
  logic        mem_ena_q;
  logic        mem_wena_q;
  logic [1:0]  mem_w_cs_q;
  logic [1:0]  mem_r_cs_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        req_err_d;
  logic [31:0] load_ext_d;

  // Error check runs on the request as it is accepted; extension runs on the
  // latched size/unsigned against the live memory read data during ACCESS.
  lsu_align #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_WORDS (NUM_WORDS)
  ) u_align (
    .chk_size_i     (req_size_i),
    .chk_addr_i     (req_addr_i),
    .chk_err_o      (req_err_d),
    .ext_rdata_i    (mem_rdata_i),
    .ext_size_i     (size_q),
    .ext_unsigned_i (unsigned_q),
    .ext_data_o     (load_ext_d)
  );

  // Controller FSM with all request, response and memory-port registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      is_store_q   <= 1'b0;
      size_q       <= SZ_NONE;
      unsigned_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
      mem_ena_q    <= DISABLED;
      mem_wena_q   <= WRITE_DISABLED;
      mem_w_cs_q   <= SZ_NONE;
      mem_r_cs_q   <= SZ_NONE;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            resp_rd_q   <= req_rd_i;
            is_store_q  <= req_is_store_i;
            size_q      <= req_size_i;
            unsigned_q  <= req_unsigned_i;
            if (req_err_d) begin
              // No memory cycle for a bad request: respond straight away.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
              state_q      <= S_RESP;
            end else begin
              mem_ena_q   <= ENABLED;
              mem_wena_q  <= req_is_store_i ? WRITE_ENABLED : WRITE_DISABLED;
              mem_w_cs_q  <= req_is_store_i ? req_size_i : SZ_NONE;
              mem_r_cs_q  <= req_is_store_i ? SZ_NONE : req_size_i;
              mem_addr_q  <= req_addr_i;
              mem_wdata_q <= req_wdata_i;
              state_q     <= S_ACCESS;
            end
          end else begin
            // Ready comes up one cycle after reset release and stays up in IDLE.
            req_ready_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          // Store commits / load data is captured at the edge leaving ACCESS.
          mem_ena_q    <= DISABLED;
          mem_wena_q   <= WRITE_DISABLED;
          mem_w_cs_q   <= SZ_NONE;
          mem_r_cs_q   <= SZ_NONE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= is_store_q ? 32'h0000_0000 : load_ext_d;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          mem_ena_q    <= DISABLED;
          mem_wena_q   <= WRITE_DISABLED;
          mem_w_cs_q   <= SZ_NONE;
          mem_r_cs_q   <= SZ_NONE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_rd_o    = resp_rd_q;
  assign resp_err_o   = resp_err_q;
  assign mem_ena_o    = mem_ena_q;
  assign mem_wena_o   = mem_wena_q;
  assign mem_w_cs_o   = mem_w_cs_q;
  assign mem_r_cs_o   = mem_r_cs_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Scoreboard bench for lsu_ctrl: a byte-array reference memory predicts each
// response when the request is accepted; a monitor pops and compares on every
// response handshake and checks the acceptance-to-valid latency.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam longint BASE_L  = 64'h0000_0000_1001_0000;
  localparam int     NBYTES  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_ena, mem_wena;
  logic [1:0]  mem_w_cs, mem_r_cs;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_rd_o(resp_rd), .resp_err_o(resp_err),
    .mem_ena_o(mem_ena), .mem_wena_o(mem_wena), .mem_w_cs_o(mem_w_cs), .mem_r_cs_o(mem_r_cs),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // ---------------- data memory attached to the DUT ----------------
  logic [31:0] dmem [0:1023];
  logic        mem_init;
  logic [31:0] moff;
  logic [9:0]  midx;
  logic [4:0]  mbit;
  assign moff = mem_addr - 32'h1001_0000;
  assign midx = moff[11:2];
  assign mbit = {mem_addr[1:0], 3'b000};

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F11;
  endfunction

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_r_cs)
      2'b11:   mem_rdata = {24'h0, dmem[midx][mbit +: 8]};
      2'b10:   mem_rdata = {16'h0, dmem[midx][mbit +: 16]};
      2'b01:   mem_rdata = dmem[midx];
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
    end else if (mem_ena && mem_wena) begin
      case (mem_w_cs)
        2'b01:   dmem[midx] <= mem_wdata;
        2'b10:   dmem[midx][mbit +: 16] <= mem_wdata[15:0];
        2'b11:   dmem[midx][mbit +: 8]  <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0] ref_b [NBYTES];

  function automatic int size_bytes(input logic [1:0] sz);
    if (sz == 2'd1) return 4;
    else if (sz == 2'd2) return 2;
    else return 1;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    if (sz == 2'd0) return 1'b1;
    if ((ua % size_bytes(sz)) != 0) return 1'b1;
    if (ua < BASE_L || ua >= BASE_L + 4 * 1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    longint v;
    int n, off;
    n = size_bytes(sz);
    off = int'(longint'(a) - BASE_L);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_b[off + k]) << (8 * k));
    if (!un && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int off;
    off = int'(longint'(a) - BASE_L);
    for (int k = 0; k < size_bytes(sz); k++) ref_b[off + k] = 8'(wd >> (8 * k));
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ena_seen = 0;
  int ena_exp  = 0;
  logic rr_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples just after the falling edge, compares on each handshake.
  initial begin : monitor
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_ena) ena_seen++;
      if (resp_valid && !prev_v) begin
        if (sbq.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
        else check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
      end
      if (resp_valid && resp_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_rd", resp_rd, e.rd);
        check("resp_err", resp_err, e.err);
      end
      prev_v = resp_valid;
    end
  end

  // Issue one request (called at a falling edge); predicts its response.
  task automatic issue(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic track, output int acc);
    exp_t e;
    int   n;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_rd = rd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (rr_rand) resp_ready = ($urandom_range(0, 2) != 0);
    end
    acc = cyc;
    if (n >= 100) begin
      check("issue_timeout", 64'd1, 64'd0);
      req_valid = 1'b0;
      return;
    end
    e.err   = model_err(sz, a);
    e.rd    = rd;
    e.acc   = acc;
    e.lat   = e.err ? 1 : 2;
    e.rdata = (e.err || st) ? 32'h0 : model_load(sz, un, a);
    if (track) begin
      sbq.push_back(e);
      if (!e.err) begin
        ena_exp++;
        if (st) model_store(sz, a, wd);
      end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 64'd1, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int acc, rel, e0, bad_words;
    logic [38:0] snap;
    logic [1:0] sz;
    logic [31:0] a;
    int r;

    rst_n = 1'b0; mem_init = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'(init_word(i) >> (8 * k));

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp", {resp_valid, resp_err, resp_rd, resp_rdata}, 39'd0);
    check("rst_mem", {mem_ena, mem_wena, mem_w_cs, mem_r_cs, mem_addr, mem_wdata}, 70'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    wait_ready();

    // store word then load it back
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 5'd3, 1'b1, acc);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 5'd7, 1'b1, acc);

    // signed/unsigned sub-word loads
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0010, 32'h80FF_7F01, 5'd1, 1'b1, acc);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0011, 32'h0, 5'd10, 1'b1, acc);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0012, 32'h0, 5'd11, 1'b1, acc);
    issue(1'b0, SZ_HALF, 1'b1, 32'h1001_0012, 32'h0, 5'd12, 1'b1, acc);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0012, 32'h0, 5'd13, 1'b1, acc);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h1001_0013, 32'h0, 5'd14, 1'b1, acc);

    // errors: no memory cycle may be issued
    wait_ready();
    e0 = ena_seen;
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0003, 32'h0, 5'd20, 1'b1, acc);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0, 5'd21, 1'b1, acc);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1000_FFFF, 32'h0, 5'd22, 1'b1, acc);
    issue(1'b0, SZ_NONE, 1'b0, 32'h1001_0010, 32'h0, 5'd23, 1'b1, acc);
    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_0011, 32'h5555_5555, 5'd24, 1'b1, acc);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h1001_1000, 32'h6666_6666, 5'd25, 1'b1, acc);
    issue(1'b1, SZ_NONE, 1'b0, 32'h1001_0010, 32'h7777_7777, 5'd26, 1'b1, acc);
    wait_ready();
    repeat (2) @(negedge clk);
    check("err_no_mem_cycle", 64'(ena_seen - e0), 64'd0);

    // range boundaries that are legal
    issue(1'b1, SZ_BYTE, 1'b0, 32'h1001_0FFF, 32'h0000_00C3, 5'd27, 1'b1, acc);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0FFF, 32'h0, 5'd28, 1'b1, acc);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0000, 32'h0, 5'd29, 1'b1, acc);
    issue(1'b0, SZ_WORD, 1'b1, 32'h1001_0FFC, 32'h0, 5'd30, 1'b1, acc);

    // back-pressure
    wait_ready();
    resp_ready = 1'b0;
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 5'd9, 1'b1, acc);
    @(negedge clk);
    check("bp_valid", resp_valid, 1'b1);
    snap = {resp_valid, resp_err, resp_rd, resp_rdata};
    req_valid = 1'b1; req_is_store = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'h1001_0012; req_rd = 5'd17;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_valid, resp_err, resp_rd, resp_rdata}, snap);
      check("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    rel = cyc;
    @(negedge clk);
    check("bp_ready_after", req_ready, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0012, 32'h0, 5'd17, 1'b1, acc);
    check("bp_accept_cycle", 64'(acc), 64'(rel + 1));

    // reset in the middle of a store
    wait_ready();
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0020, 32'h1234_5678, 5'd4, 1'b0, acc);
    #3;
    check("mid_ena_before", mem_ena, 1'b1);
    ena_exp++;
    rst_n = 1'b0;
    #1;
    check("mid_ena_wena", {mem_ena, mem_wena}, 2'b00);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_resp", {resp_valid, resp_err, resp_rd, resp_rdata}, 39'd0);
    check("mid_rst_mem", {mem_w_cs, mem_r_cs, mem_addr, mem_wdata}, 68'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0020, 32'h0, 5'd5, 1'b1, acc);

    // randomized traffic
    rr_rand = 1'b1;
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 7);
      sz = (r == 0) ? SZ_NONE : 2'(1 + (r % 3));
      r = $urandom_range(0, 11);
      if (r == 0)      a = 32'h1001_0000 - 32'($urandom_range(1, 8));
      else if (r == 1) a = 32'h1001_1000 + 32'($urandom_range(0, 7));
      else if (r == 2) a = $urandom;
      else begin
        a = 32'h1001_0000 + 32'($urandom_range(0, NBYTES - 1));
        if ($urandom_range(0, 4) != 0) begin
          if (sz == SZ_WORD) a[1:0] = 2'b00;
          else if (sz == SZ_HALF) a[0] = 1'b0;
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        resp_ready = ($urandom_range(0, 2) != 0);
      end
      issue(1'(($urandom_range(0, 1))), sz, 1'(($urandom_range(0, 1))), a, $urandom,
            5'($urandom_range(0, 31)), 1'b1, acc);
    end
    rr_rand = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    check("mem_cycles", 64'(ena_seen), 64'(ena_exp));
    bad_words = 0;
    for (int i = 0; i < 1024; i++)
      if (dmem[i] !== {ref_b[4 * i + 3], ref_b[4 * i + 2], ref_b[4 * i + 1], ref_b[4 * i]})
        bad_words++;
    check("mem_contents", 64'(bad_words), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
